// File: rtl/ex_muldiv_unit_if.sv
// Execute-stage request/response bundle between the pipeline and the RV32M multiply/divide unit.
// E_MulDiv acts as the request valid: the pipeline holds it, and the operands, steady while E_MulDivStall is high.
// The unit accepts a request when it is idle and raises E_MulDivDone for one cycle with the result.
// E_Flush kills any request or operation in flight and has priority over a new start.
interface ex_muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  E_Flush;
    logic                  E_MulDiv;
    logic [2:0]            E_funct3;
    logic [DATA_WIDTH-1:0] E_SrcA;
    logic [DATA_WIDTH-1:0] E_SrcB;
    logic [4:0]            E_Rd;
    logic                  E_MulDivStall;
    logic                  E_MulDivDone;
    logic [DATA_WIDTH-1:0] E_MulDivResult;
    logic [4:0]            E_MulDivRd;

    modport master (
        output E_Flush, E_MulDiv, E_funct3, E_SrcA, E_SrcB, E_Rd,
        input  E_MulDivStall, E_MulDivDone, E_MulDivResult, E_MulDivRd
    );

    modport slave (
        input  E_Flush, E_MulDiv, E_funct3, E_SrcA, E_SrcB, E_Rd,
        output E_MulDivStall, E_MulDivDone, E_MulDivResult, E_MulDivRd
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on operand magnitudes,
// one bit per cycle, with single-cycle early completion for divide-by-zero and signed overflow.
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    ex_muldiv_unit_if.slave  mdu,
    output logic [1:0]       dbg_state
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             is_div_q;
    logic             sel_rem_q;
    logic             mul_low_q;
    logic             res_neg_q;
    logic             rem_neg_q;
    logic [4:0]       rd_q;
    logic [2*W-1:0]   acc_q;
    logic [2*W-1:0]   mcand_q;
    logic [W-1:0]     mplier_q;
    logic [W-1:0]     rem_q;
    logic [W-1:0]     quo_q;
    logic [W-1:0]     divisor_q;
    logic [W-1:0]     result_q;
    logic [4:0]       result_rd_q;

    // Start-time decode of the instruction sitting in EX
    logic         start;
    logic         is_div;
    logic         a_signed;
    logic         b_signed;
    logic         a_neg;
    logic         b_neg;
    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag;
    logic         div_by_zero;
    logic         div_ovf;
    logic [W-1:0] early_res;

    always_comb begin
        start       = (state == S_IDLE) && mdu.E_MulDiv && !mdu.E_Flush;
        is_div      = mdu.E_funct3[2];
        // MUL is treated as signed x signed; its low word is identical either way
        a_signed    = is_div ? !mdu.E_funct3[0] : (mdu.E_funct3[1:0] != 2'b11);
        b_signed    = is_div ? !mdu.E_funct3[0] : !mdu.E_funct3[1];
        a_neg       = a_signed && mdu.E_SrcA[W-1];
        b_neg       = b_signed && mdu.E_SrcB[W-1];
        a_mag       = a_neg ? -mdu.E_SrcA : mdu.E_SrcA;
        b_mag       = b_neg ? -mdu.E_SrcB : mdu.E_SrcB;
        div_by_zero = is_div && (mdu.E_SrcB == '0);
        div_ovf     = is_div && !mdu.E_funct3[0] && (mdu.E_SrcA == {1'b1, {(W-1){1'b0}}})
                      && (&mdu.E_SrcB);
        early_res   = '0;
        if (div_by_zero)
            early_res = mdu.E_funct3[1] ? mdu.E_SrcA : '1;
        else
            early_res = mdu.E_funct3[1] ? '0 : mdu.E_SrcA;
    end

    // One iteration of both datapaths; only the one matching the latched op is used
    logic [2*W-1:0] acc_nxt;
    logic [W:0]     rem_sh;
    logic [W:0]     rem_diff;
    logic           rem_ge;
    logic [W-1:0]   rem_nxt;
    logic [W-1:0]   quo_nxt;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   mul_res;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;
    logic [W-1:0]   final_res;
    logic           last_iter;

    always_comb begin
        acc_nxt   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        rem_sh    = {rem_q, quo_q[W-1]};
        rem_diff  = rem_sh - {1'b0, divisor_q};
        rem_ge    = (rem_sh >= {1'b0, divisor_q});
        rem_nxt   = rem_ge ? rem_diff[W-1:0] : rem_sh[W-1:0];
        quo_nxt   = {quo_q[W-2:0], rem_ge};
        prod_fix  = res_neg_q ? -acc_nxt : acc_nxt;
        mul_res   = mul_low_q ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
        quo_fix   = res_neg_q ? -quo_nxt : quo_nxt;
        rem_fix   = rem_neg_q ? -rem_nxt : rem_nxt;
        final_res = is_div_q ? (sel_rem_q ? rem_fix : quo_fix) : mul_res;
        last_iter = (cnt == CNT_W'(W-1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            is_div_q    <= 1'b0;
            sel_rem_q   <= 1'b0;
            mul_low_q   <= 1'b0;
            res_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            rd_q        <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
            result_q    <= '0;
            result_rd_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_div_q  <= is_div;
                        sel_rem_q <= mdu.E_funct3[1];
                        mul_low_q <= (mdu.E_funct3[1:0] == 2'b00);
                        res_neg_q <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        rd_q      <= mdu.E_Rd;
                        acc_q     <= '0;
                        mcand_q   <= {{W{1'b0}}, a_mag};
                        mplier_q  <= b_mag;
                        rem_q     <= '0;
                        quo_q     <= a_mag;
                        divisor_q <= b_mag;
                        cnt       <= '0;
                        if (div_by_zero || div_ovf) begin
                            result_q    <= early_res;
                            result_rd_q <= mdu.E_Rd;
                            state       <= S_DONE;
                        end else begin
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (mdu.E_Flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc_q    <= acc_nxt;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        rem_q    <= rem_nxt;
                        quo_q    <= quo_nxt;
                        cnt      <= cnt + CNT_W'(1);
                        if (last_iter) begin
                            result_q    <= final_res;
                            result_rd_q <= rd_q;
                            state       <= S_DONE;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // A flush landing in the DONE cycle kills the op, so the pulse is masked
    assign mdu.E_MulDivStall  = start || (state == S_BUSY);
    assign mdu.E_MulDivDone   = (state == S_DONE) && !mdu.E_Flush;
    assign mdu.E_MulDivResult = result_q;
    assign mdu.E_MulDivRd     = result_rd_q;
    assign dbg_state          = state;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M cases, flush/reset interruption and random ops
// compared against a plain-arithmetic reference model.
module tb_ex_muldiv_unit;
    localparam int W = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    ex_muldiv_unit_if #(.DATA_WIDTH(W)) mdu_if ();

    ex_muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mdu       (mdu_if),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [4:0]   exp_rd_q[$];
    logic [W-1:0] last_res;
    logic [4:0]   last_rd;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // RV32M semantics straight from the ISA rules, using wide host arithmetic
    function automatic logic [W-1:0] ref_model(input logic [2:0] f, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint      sa, sb;
        logic [63:0] p;
        int          ia, ib;
        if (!f[2]) begin
            sa = (f[1:0] == 2'b11) ? longint'(a) : longint'(signed'(a));
            sb = f[1] ? longint'(b) : longint'(signed'(b));
            p  = 64'(sa * sb);
            return (f[1:0] == 2'b00) ? p[31:0] : p[63:32];
        end
        if (b == '0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : a;
            ia = signed'(a);
            ib = signed'(b);
            return f[1] ? 32'(ia % ib) : 32'(ia / ib);
        end
        return f[1] ? (a % b) : (a / b);
    endfunction

    function automatic bit is_early(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        return f[2] && (b == '0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic drive_idle();
        mdu_if.E_MulDiv = 1'b0;
        mdu_if.E_Flush  = 1'b0;
    endtask

    // Issue one op in T0 (mid-cycle), follow it to Done and check timing, result and Rd
    task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] rd, input bit fwd_noise);
        int           done_cyc;
        int           stall_cnt;
        int           exp_lat;
        logic [W-1:0] exp_r;
        logic [4:0]   exp_rd;
        done_cyc  = -1;
        stall_cnt = 0;
        exp_lat   = is_early(f, a, b) ? 1 : 33;
        exp_q.push_back(ref_model(f, a, b));
        exp_rd_q.push_back(rd);
        @(negedge clk);
        mdu_if.E_MulDiv = 1'b1;
        mdu_if.E_funct3 = f;
        mdu_if.E_SrcA   = a;
        mdu_if.E_SrcB   = b;
        mdu_if.E_Rd     = rd;
        #1;
        if (mdu_if.E_MulDivStall) stall_cnt++;
        for (int k = 1; k <= 40 && done_cyc < 0; k++) begin
            @(negedge clk);
            if (mdu_if.E_MulDivDone) begin
                done_cyc = k;
                check_eq("stall_at_done", 32'(mdu_if.E_MulDivStall), 32'h0);
                exp_r  = exp_q.pop_front();
                exp_rd = exp_rd_q.pop_front();
                check_eq($sformatf("result f=%0d a=%08h b=%08h", f, a, b), mdu_if.E_MulDivResult, exp_r);
                check_eq("rd_echo", 32'(mdu_if.E_MulDivRd), 32'(exp_rd));
                last_res = exp_r;
                last_rd  = exp_rd;
            end else if (mdu_if.E_MulDivStall) begin
                stall_cnt++;
            end
            if (fwd_noise && k == 5) begin
                mdu_if.E_SrcA = $urandom;
                mdu_if.E_SrcB = $urandom;
            end
        end
        mdu_if.E_MulDiv = 1'b0;
        if (done_cyc < 0) begin
            void'(exp_q.pop_front());
            void'(exp_rd_q.pop_front());
        end
        check_eq("done_cycle", 32'(done_cyc), 32'(exp_lat));
        check_eq("stall_cycles", 32'(stall_cnt), 32'(exp_lat));
        @(negedge clk);
        check_eq("done_one_shot", 32'(mdu_if.E_MulDivDone), 32'h0);
        check_eq("result_held", mdu_if.E_MulDivResult, last_res);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_stall"},  32'(mdu_if.E_MulDivStall), 32'h0);
        check_eq({tag, "_done"},   32'(mdu_if.E_MulDivDone), 32'h0);
        check_eq({tag, "_result"}, mdu_if.E_MulDivResult, 32'h0);
        check_eq({tag, "_rd"},     32'(mdu_if.E_MulDivRd), 32'h0);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] specials[5];
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 300));
        return $urandom;
    endfunction

    logic [2:0] dir_f[12];
    logic [W-1:0] dir_a[12];
    logic [W-1:0] dir_b[12];

    initial begin
        int done_seen;
        dir_f = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
        dir_a = '{32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                  32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        dir_b = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2, 32'h2,
                  32'd7, 32'd7, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

        // Clock/reset
        rst             = 1'b1;
        mdu_if.E_Flush  = 1'b0;
        mdu_if.E_MulDiv = 1'b0;
        mdu_if.E_funct3 = '0;
        mdu_if.E_SrcA   = '0;
        mdu_if.E_SrcB   = '0;
        mdu_if.E_Rd     = '0;
        last_res        = '0;
        last_rd         = '0;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++)
            run_op(dir_f[i], dir_a[i], dir_b[i], 5'(i + 1), 1'b0);

        // Flush at T10 of a DIV: no Done, stall released from T11
        @(negedge clk);
        mdu_if.E_MulDiv = 1'b1;
        mdu_if.E_funct3 = 3'd4;
        mdu_if.E_SrcA   = 32'd1000;
        mdu_if.E_SrcB   = 32'd3;
        mdu_if.E_Rd     = 5'd20;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        mdu_if.E_Flush = 1'b1;
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        check_eq("flush_stall_t11", 32'(mdu_if.E_MulDivStall), 32'h0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mdu_if.E_MulDivDone) done_seen++;
        end
        check_eq("flush_no_done", 32'(done_seen), 32'h0);
        check_eq("flush_result_held", mdu_if.E_MulDivResult, last_res);
        run_op(3'd0, 32'd123, 32'd456, 5'd21, 1'b0);

        // Reset at T5 of a MUL
        @(negedge clk);
        mdu_if.E_MulDiv = 1'b1;
        mdu_if.E_funct3 = 3'd0;
        mdu_if.E_SrcA   = 32'd9;
        mdu_if.E_SrcB   = 32'd9;
        mdu_if.E_Rd     = 5'd9;
        for (int k = 1; k <= 5; k++) @(negedge clk);
        rst             = 1'b1;
        mdu_if.E_MulDiv = 1'b0;
        #1;
        check_outputs_zero("midop_reset");
        last_res = '0;
        last_rd  = '0;
        @(negedge clk);
        rst = 1'b0;
        run_op(3'd5, 32'd100, 32'd7, 5'd12, 1'b1);

        // Non-M instructions in IDLE: no stall, outputs hold
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mdu_if.E_funct3 = 3'($urandom);
            mdu_if.E_SrcA   = $urandom;
            #1;
            check_eq("nonm_stall", 32'(mdu_if.E_MulDivStall), 32'h0);
            check_eq("nonm_result", mdu_if.E_MulDivResult, last_res);
            check_eq("nonm_rd", 32'(mdu_if.E_MulDivRd), 32'(last_rd));
        end

        // Random ops
        for (int i = 0; i < 40; i++)
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
